// File: rtl/video_timing_pkg.sv
// Shared timing constants and helpers for the
// video sync generator and the input sync receiver.
package video_timing_pkg;

  localparam int TIMING_W = 12;

  typedef logic [TIMING_W-1:0] tcnt_t;

  function automatic tcnt_t vt_total(
    input tcnt_t disp,
    input tcnt_t fp,
    input tcnt_t sync,
    input tcnt_t bp
  );
    return disp + fp + sync + bp;
  endfunction

  function automatic tcnt_t vt_sync_start(
    input tcnt_t disp,
    input tcnt_t fp
  );
    return disp + fp;
  endfunction

  function automatic tcnt_t vt_sync_end(
    input tcnt_t disp,
    input tcnt_t fp,
    input tcnt_t sync
  );
    return disp + fp + sync;
  endfunction

  // Widened by one bit so the sum cannot overflow before the modulo
  function automatic tcnt_t vt_half_col(
    input tcnt_t disp,
    input tcnt_t fp,
    input tcnt_t tot
  );
    logic [TIMING_W:0] c;
    c = {1'b0, disp} + {1'b0, fp} + {2'b0, tot[TIMING_W-1:1]};
    if (c >= {1'b0, tot})
      c = c - {1'b0, tot};
    return c[TIMING_W-1:0];
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Up counter that reloads to zero after limit-1.
// nxt exposes the value the counter takes on its next step.
module wrap_counter #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic [W-1:0] nxt,
  output logic         last
);

  assign last = (count == limit - W'(1));
  assign nxt  = last ? '0 : count + W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (en)
      count <= nxt;
  end

endmodule

// File: rtl/video_timing_gen.sv
// Output-side video timing generator: sync, display
// enable, coordinates and strobes, progressive or interlaced.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter tcnt_t h_disp           = 12'd640,
  parameter tcnt_t h_fporch         = 12'd16,
  parameter tcnt_t h_sync           = 12'd96,
  parameter tcnt_t h_bporch         = 12'd48,
  parameter tcnt_t v_disp           = 12'd350,
  parameter tcnt_t v_fporch         = 12'd37,
  parameter tcnt_t v_sync           = 12'd2,
  parameter tcnt_t v_bporch         = 12'd60,
  parameter logic  hs_polarity      = 1'b1,
  parameter logic  vs_polarity      = 1'b0,
  parameter logic  frame_interlaced = 1'b0
) (
  input  logic        clk25,
  input  logic        reset,
  input  logic        enable,
  output logic        hs,
  output logic        vs,
  output logic        de,
  output logic        de_next,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        field,
  output logic        line_start,
  output logic        frame_start
);

  localparam tcnt_t H_TOT =
    vt_total(h_disp, h_fporch, h_sync, h_bporch);
  localparam tcnt_t V_TOT =
    vt_total(v_disp, v_fporch, v_sync, v_bporch);
  localparam tcnt_t HS_S = vt_sync_start(h_disp, h_fporch);
  localparam tcnt_t HS_E =
    vt_sync_end(h_disp, h_fporch, h_sync);
  localparam tcnt_t VS_S = vt_sync_start(v_disp, v_fporch);
  localparam tcnt_t VS_E =
    vt_sync_end(v_disp, v_fporch, v_sync);
  localparam tcnt_t HALF =
    vt_half_col(h_disp, h_fporch, H_TOT);

  // Counters hold the position presented on the next edge
  tcnt_t hc, hc_nxt, vc, vc_nxt, vlim, vc_adv, vcol;
  logic  h_last, v_last, fld;
  logic  de_d, dn_d, hs_act, vs_act, vs_on, vs_off;

  assign vlim = fld ? V_TOT + 12'd1 : V_TOT;

  wrap_counter #(.W(TIMING_W)) u_hc (
    .clk   (clk25),
    .rst   (reset),
    .clr   (~enable),
    .en    (1'b1),
    .limit (H_TOT),
    .count (hc),
    .nxt   (hc_nxt),
    .last  (h_last)
  );

  wrap_counter #(.W(TIMING_W)) u_vc (
    .clk   (clk25),
    .rst   (reset),
    .clr   (~enable),
    .en    (h_last),
    .limit (vlim),
    .count (vc),
    .nxt   (vc_nxt),
    .last  (v_last)
  );

  always_ff @(posedge clk25 or posedge reset) begin
    if (reset)
      fld <= 1'b0;
    else if (!enable)
      fld <= 1'b0;
    else if (h_last && v_last)
      fld <= frame_interlaced & ~fld;
  end

  assign vc_adv = h_last ? vc_nxt : vc;
  assign de_d   = (hc < h_disp) && (vc < v_disp);
  assign dn_d   = (hc_nxt < h_disp) && (vc_adv < v_disp);
  assign hs_act = (hc >= HS_S) && (hc < HS_E);

  // Field 1 moves the vsync edges to the half-line column
  assign vcol   = fld ? HALF : HS_S;
  assign vs_on  = (vc > VS_S) || ((vc == VS_S) && (hc >= vcol));
  assign vs_off = (vc > VS_E) || ((vc == VS_E) && (hc >= vcol));
  assign vs_act = vs_on && !vs_off;

  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      hs          <= ~hs_polarity;
      vs          <= ~vs_polarity;
      de          <= 1'b0;
      de_next     <= 1'b0;
      x           <= '0;
      y           <= '0;
      field       <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (!enable) begin
      hs          <= ~hs_polarity;
      vs          <= ~vs_polarity;
      de          <= 1'b0;
      de_next     <= 1'b0;
      x           <= '0;
      y           <= '0;
      field       <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hs          <= hs_act ? hs_polarity : ~hs_polarity;
      vs          <= vs_act ? vs_polarity : ~vs_polarity;
      de          <= de_d;
      de_next     <= dn_d;
      x           <= de_d ? hc : '0;
      y           <= de_d ? vc : '0;
      field       <= fld;
      line_start  <= (hc == '0);
      frame_start <= (hc == '0) && (vc == '0);
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: progressive, interlaced and
// inverted-polarity instances with the small timing set.
module tb_video_timing_gen;

  logic        clk;
  logic        reset;
  logic        en [3];
  logic        hs [3];
  logic        vs [3];
  logic        de [3];
  logic        dn [3];
  logic        ls [3];
  logic        fs [3];
  logic        fld [3];
  logic [11:0] x [3];
  logic [11:0] y [3];
  logic [30:0] ov [3];

  int n_chk;
  int n_pass;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_ov
    assign ov[g] = {hs[g], vs[g], de[g], dn[g], ls[g],
                    fs[g], fld[g], x[g], y[g]};
  end

  video_timing_gen #(
    .h_disp(12'd40), .h_fporch(12'd10),
    .h_sync(12'd5), .h_bporch(12'd15),
    .v_disp(12'd30), .v_fporch(12'd3),
    .v_sync(12'd2), .v_bporch(12'd4),
    .hs_polarity(1'b1), .vs_polarity(1'b0),
    .frame_interlaced(1'b0)
  ) u_prog (
    .clk25(clk), .reset(reset), .enable(en[0]),
    .hs(hs[0]), .vs(vs[0]), .de(de[0]),
    .de_next(dn[0]), .x(x[0]), .y(y[0]),
    .field(fld[0]), .line_start(ls[0]),
    .frame_start(fs[0])
  );

  video_timing_gen #(
    .h_disp(12'd40), .h_fporch(12'd10),
    .h_sync(12'd5), .h_bporch(12'd15),
    .v_disp(12'd30), .v_fporch(12'd3),
    .v_sync(12'd2), .v_bporch(12'd4),
    .hs_polarity(1'b1), .vs_polarity(1'b0),
    .frame_interlaced(1'b1)
  ) u_intl (
    .clk25(clk), .reset(reset), .enable(en[1]),
    .hs(hs[1]), .vs(vs[1]), .de(de[1]),
    .de_next(dn[1]), .x(x[1]), .y(y[1]),
    .field(fld[1]), .line_start(ls[1]),
    .frame_start(fs[1])
  );

  video_timing_gen #(
    .h_disp(12'd40), .h_fporch(12'd10),
    .h_sync(12'd5), .h_bporch(12'd15),
    .v_disp(12'd30), .v_fporch(12'd3),
    .v_sync(12'd2), .v_bporch(12'd4),
    .hs_polarity(1'b0), .vs_polarity(1'b1),
    .frame_interlaced(1'b0)
  ) u_pol (
    .clk25(clk), .reset(reset), .enable(en[2]),
    .hs(hs[2]), .vs(vs[2]), .de(de[2]),
    .de_next(dn[2]), .x(x[2]), .y(y[2]),
    .field(fld[2]), .line_start(ls[2]),
    .frame_start(fs[2])
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Position of cycle k after start: 70-cycle lines,
  // 39-line fields, 40-line field 1 when interlaced
  function automatic void pos(
    input  int k,
    input  bit il,
    output int hc,
    output int vc,
    output bit f
  );
    int kk;
    f = 1'b0;
    if (!il) begin
      kk = k % 2730;
    end else begin
      kk = k % 5530;
      if (kk >= 2730) begin
        f = 1'b1;
        kk -= 2730;
      end
    end
    hc = kk % 70;
    vc = kk / 70;
  endfunction

  function automatic logic [30:0] expv(
    input int k,
    input bit il,
    input bit hp,
    input bit vp
  );
    int hc, vc, hn, vn, col;
    bit f, fn, d, dnx, ha, va;
    pos(k, il, hc, vc, f);
    pos(k + 1, il, hn, vn, fn);
    d   = (hc < 40) && (vc < 30);
    dnx = (hn < 40) && (vn < 30);
    ha  = (hc >= 50) && (hc < 55);
    col = f ? 15 : 50;
    va  = ((vc > 33) || (vc == 33 && hc >= col)) &&
          ((vc < 35) || (vc == 35 && hc < col));
    return {ha ? hp : ~hp, va ? vp : ~vp, d, dnx,
            hc == 0, hc == 0 && vc == 0, f,
            d ? 12'(hc) : 12'd0, d ? 12'(vc) : 12'd0};
  endfunction

  function automatic logic [30:0] rv(input bit hp, input bit vp);
    return {~hp, ~vp, 29'd0};
  endfunction

  initial begin
    int decnt, hsf, hsl, xmax, ymax, fsp;
    int vfall, vrise, f1s, f1e, vi;
    logic pdn, pvs0, pvs1, pf1;
    n_chk  = 0;
    n_pass = 0;
    decnt = 0; hsf = -1; hsl = -1; xmax = 0; ymax = 0;
    fsp = -1; vfall = -1; vrise = -1;
    f1s = -1; f1e = -1; vi = -1;
    pdn = 1'b0; pvs0 = 1'b1; pvs1 = 1'b1; pf1 = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) en[i] = 1'b1;

    repeat (10) begin
      @(negedge clk);
      chk("rst_prog", ov[0], rv(1, 0));
      chk("rst_intl", ov[1], rv(1, 0));
      chk("rst_pol", ov[2], rv(0, 1));
    end
    reset = 1'b0;

    for (int k = 0; k < 5600; k++) begin
      @(negedge clk);
      if (k == 0) begin
        chk("start_de", de[0], 1);
        chk("start_fs", fs[0], 1);
        chk("start_xy", {x[0], y[0]}, 0);
      end
      chk("prog", ov[0], expv(k, 0, 1, 0));
      chk("intl", ov[1], expv(k, 1, 1, 0));
      chk("pol", ov[2], expv(k, 0, 0, 1));
      if (k > 0) chk("de_next", de[0], pdn);
      pdn = dn[0];
      if (k < 70 && de[0]) decnt++;
      if (k < 70 && hs[0]) begin
        if (hsf < 0) hsf = k;
        hsl = k;
      end
      if (de[0] && int'(x[0]) > xmax) xmax = int'(x[0]);
      if (de[0] && int'(y[0]) > ymax) ymax = int'(y[0]);
      if (k > 0 && fs[0] && fsp < 0) fsp = k;
      if (k > 0 && vs[0] != pvs0) begin
        if (!vs[0] && vfall < 0) vfall = k;
        if (vs[0] && vrise < 0) vrise = k;
      end
      if (k > 0 && fld[1] != pf1) begin
        if (fld[1] && f1s < 0) f1s = k;
        if (!fld[1] && f1e < 0) f1e = k;
      end
      if (fld[1] && !vs[1] && pvs1 && vi < 0) vi = k;
      pvs0 = vs[0];
      pvs1 = vs[1];
      pf1  = fld[1];
    end

    chk("de_per_line", decnt, 40);
    chk("hs_first", hsf, 50);
    chk("hs_last", hsl, 54);
    chk("x_max", xmax, 39);
    chk("y_max", ymax, 29);
    chk("frame_period", fsp, 2730);
    chk("vs_fall", vfall, 33 * 70 + 50);
    chk("vs_rise", vrise, 35 * 70 + 50);
    chk("field0_len", f1s, 2730);
    chk("field1_len", f1e - f1s, 2800);
    chk("vs_f1_fall", vi, 2730 + 33 * 70 + 15);
    chk("vs_f1_col", vi % 70, 15);

    // Enable drop inside field 1 at (20,12)
    en[1] = 1'b0;
    @(negedge clk);
    chk("idle_intl", ov[1], rv(1, 0));
    en[1] = 1'b1;
    for (int k = 0; k <= 3590; k++) @(negedge clk);
    chk("dis_pos", ov[1], expv(3590, 1, 1, 0));
    chk("dis_field", fld[1], 1);
    en[1] = 1'b0;
    @(negedge clk);
    chk("dis_idle", ov[1], rv(1, 0));
    en[1] = 1'b1;
    @(negedge clk);
    chk("dis_restart0", ov[1], expv(0, 1, 1, 0));
    @(negedge clk);
    chk("dis_restart1", ov[1], expv(1, 1, 1, 0));

    // Reset pulse between edges at (20,12)
    en[0] = 1'b0;
    @(negedge clk);
    en[0] = 1'b1;
    for (int k = 0; k <= 860; k++) @(negedge clk);
    chk("rp_pos", ov[0], expv(860, 0, 1, 0));
    #2 reset = 1'b1;
    #1;
    chk("rp_async", ov[0], rv(1, 0));
    chk("rp_async_pol", ov[2], rv(0, 1));
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rp_restart0", ov[0], expv(0, 0, 1, 0));
    @(negedge clk);
    chk("rp_restart1", ov[0], expv(1, 0, 1, 0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
